// File: rtl/dual_port_issue_fifo_pkg.sv
// Shared types and defaults for the fetch->decode issue FIFO.
package fifo_pkg;
  localparam int DATA_W_DEF = 104;
  localparam int DEPTH_DEF  = 16;

  typedef logic [DATA_W_DEF-1:0] fifo_entry_t;

  function automatic int unsigned free_slots(input int unsigned cnt,
                                             input int unsigned depth = DEPTH_DEF);
    return depth - cnt;
  endfunction
endpackage

// File: rtl/dual_port_issue_fifo_mem.sv
// DEPTH x DATA_W storage: two write ports, two asynchronous read ports.
// The write addresses are always distinct, so the two port writes never collide.
module fifo_mem_2w2r
  import fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                i_clk,
  input  logic [1:0]          i_we,
  input  logic [2*AW-1:0]     i_waddr,
  input  logic [2*DATA_W-1:0] i_wdata,
  input  logic [2*AW-1:0]     i_raddr,
  output logic [2*DATA_W-1:0] o_rdata
);
  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we[0]) r_mem[i_waddr[0 +: AW]]  <= i_wdata[0 +: DATA_W];
    if (i_we[1]) r_mem[i_waddr[AW +: AW]] <= i_wdata[DATA_W +: DATA_W];
  end

  for (genvar p = 0; p < 2; p++) begin : g_rd
    assign o_rdata[p*DATA_W +: DATA_W] = r_mem[i_raddr[p*AW +: AW]];
  end
endmodule

// File: rtl/dual_port_issue_fifo.sv
// 2-in/2-out circular issue queue with exact occupancy, almost-full and one-cycle flush.
// Define FIFO_BYPASS_EN to forward slot0 of a push into an empty queue straight to pop_data.
module dual_port_issue_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int AF_SLACK = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic [1:0]             push_en,
  input  logic [2*DATA_W-1:0]    push_data,
  input  logic [1:0]             pop_en,
  output logic [2*DATA_W-1:0]    pop_data,
  output logic [1:0]             pop_valid,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full,
  output logic                   almost_full
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]    r_count, w_free;
  logic [1:0]          w_push_n, w_acc_n, w_pop_en, w_pop_m, w_wr_n, w_rd_n;
  logic                w_push_ok, w_byp, w_byp_take, w_live;
  logic [1:0]          w_we;
  logic [2*PTR_W-1:0]  w_waddr, w_raddr;
  logic [2*DATA_W-1:0] w_wdata, w_rdata;

  // Illegal 2'b10 encodings collapse to "no request".
  assign w_push_n = (push_en == 2'b11) ? 2'd2 : (push_en == 2'b01) ? 2'd1 : 2'd0;
  assign w_pop_en = (pop_en == 2'b10) ? 2'b00 : pop_en;

  assign w_free    = CNT_W'(free_slots(32'(r_count), DEPTH));
  assign w_push_ok = CNT_W'(w_push_n) <= w_free;
  assign w_acc_n   = w_push_ok ? w_push_n : 2'd0;
  assign w_live    = !(rst || flush);

`ifdef FIFO_BYPASS_EN
  assign w_byp = (r_count == '0) && push_en[0];
`else
  assign w_byp = 1'b0;
`endif
  assign w_byp_take = w_byp && w_pop_en[0];

  assign pop_valid   = {r_count > CNT_W'(1), (r_count != '0) || w_byp};
  assign w_pop_m     = {1'b0, w_pop_en[0] & pop_valid[0]} + {1'b0, w_pop_en[1] & pop_valid[1]};
  assign count       = r_count;
  assign empty       = (r_count == '0);
  assign full        = w_free < CNT_W'(2);
  assign almost_full = w_free <= CNT_W'(AF_SLACK);

  // A consumed bypass entry is never stored, so it advances neither pointer.
  assign w_wr_n = w_acc_n - {1'b0, w_byp_take};
  assign w_rd_n = w_pop_m - {1'b0, w_byp_take};

  assign w_we    = {w_live && (w_wr_n == 2'd2), w_live && (w_wr_n != 2'd0)};
  assign w_waddr = {r_wr_ptr + PTR_W'(1), r_wr_ptr};
  assign w_wdata = {push_data[DATA_W +: DATA_W],
                    w_byp_take ? push_data[DATA_W +: DATA_W] : push_data[0 +: DATA_W]};
  assign w_raddr = {r_rd_ptr + PTR_W'(1), r_rd_ptr};

  assign pop_data = {w_rdata[DATA_W +: DATA_W],
                     w_byp ? push_data[0 +: DATA_W] : w_rdata[0 +: DATA_W]};

  fifo_mem_2w2r #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_mem (
    .i_clk   (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + PTR_W'(w_wr_n);
      r_rd_ptr <= r_rd_ptr + PTR_W'(w_rd_n);
      r_count  <= r_count + CNT_W'(w_acc_n) - CNT_W'(w_pop_m);
    end
  end
endmodule
